// File: rtl/tdc_meas_ctrl_if.sv
// Result bus of the TDC measurement sequencer: one statistics record per
// request, handed over with a valid/ready handshake.
interface tdc_meas_ctrl_if #(
  parameter int HW_W         = 7,
  parameter int MAX_AVG_LOG2 = 7
);
  logic                         res_valid;
  logic                         res_ready;
  logic [HW_W+MAX_AVG_LOG2-1:0] res_sum;
  logic [HW_W-1:0]              res_mean;
  logic [HW_W-1:0]              res_min;
  logic [HW_W-1:0]              res_max;
  logic                         res_err;

  modport master (
    output res_valid, res_sum, res_mean, res_min, res_max, res_err,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_sum, res_mean, res_min, res_max, res_err,
    output res_ready
  );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the delay-line TDC: drives launch/capture/strobe,
// averages 2^k Hamming-weight samples and returns sum/mean/min/max/err.
module tdc_meas_ctrl #(
  parameter int N            = 64,
  parameter int HW_W         = $clog2(N) + 1,
  parameter int MAX_AVG_LOG2 = 7,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  input  logic [2:0]      cfg_avg_log2,
  input  logic [3:0]      cfg_gap,
  input  logic [3:0]      cfg_settle,
  input  logic [3:0]      cfg_pg,
  output logic            clk_launch,
  output logic            clk_capture,
  output logic            val_in,
  output logic            pg_src,
  output logic            pg_bypass,
  output logic            pg_in,
  output logic            pg_tog,
  input  logic [HW_W-1:0] hw,
  input  logic            val_out,
  output logic            busy,
  tdc_meas_ctrl_if.master res_if
);

  localparam int SUM_W = HW_W + MAX_AVG_LOG2;
  localparam int CNT_W = MAX_AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int TM_W  = (TO_W > 4) ? TO_W : 4;

  localparam logic [2:0] AVG_MAX = 3'(MAX_AVG_LOG2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_RELAX   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  typedef struct packed {
    logic [2:0] avg_log2;
    logic [3:0] gap;
    logic [3:0] settle;
    logic [3:0] pg;
  } cfg_t;

  logic [2:0]       state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [TM_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [HW_W-1:0]  min_q, min_d;
  logic [HW_W-1:0]  max_q, max_d;
  logic             err_q, err_d;
  logic [1:0]       val_sync_q, val_sync_d;
  logic             launch_q, launch_d;
  logic             capture_q, capture_d;
  logic             val_in_q, val_in_d;
  logic [3:0]       pg_q, pg_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic             val_s;
  logic [CNT_W-1:0] target;

  assign val_s  = val_sync_q[1];
  assign target = CNT_W'(1) << cfg_q.avg_log2;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    min_d      = min_q;
    max_d      = max_q;
    err_d      = err_q;
    val_sync_d = {val_sync_q[0], val_out};

    unique case (state_q)
      S_IDLE: begin
        if (start && en) begin
          cfg_d.avg_log2 = (int'(cfg_avg_log2) > MAX_AVG_LOG2) ? AVG_MAX : cfg_avg_log2;
          cfg_d.gap      = (cfg_gap == 4'd0) ? 4'd1 : cfg_gap;
          cfg_d.settle   = (cfg_settle == 4'd0) ? 4'd1 : cfg_settle;
          cfg_d.pg       = cfg_pg;
          cnt_d          = '0;
          sum_d          = '0;
          err_d          = 1'b0;
          min_d          = '1;
          max_d          = '0;
          state_d        = S_ARM;
        end
      end
      S_ARM:     state_d = S_LAUNCH;
      S_LAUNCH:  if (tmr_q >= TM_W'(cfg_q.gap - 4'd1)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_WAIT;
      S_WAIT: begin
        // A result wins over a timeout landing in the same cycle.
        if (val_s) begin
          sum_d   = sum_q + SUM_W'(hw);
          min_d   = (hw < min_q) ? hw : min_q;
          max_d   = (hw > max_q) ? hw : max_q;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_RELAX;
        end else if (tmr_q == TM_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RELAX: begin
        // Last sample: linger until the TDC drops its strobe.
        if (tmr_q >= TM_W'(cfg_q.settle - 4'd1)) begin
          if (cnt_q < target) state_d = S_ARM;
          else if (!val_s)    state_d = S_DONE;
        end
      end
      S_DONE:    if (res_if.res_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (!en) state_d = S_IDLE;

    // One shared dwell timer, restarted on every state change.
    if (state_d != state_q) tmr_d = '0;
    else                    tmr_d = (&tmr_q) ? tmr_q : tmr_q + 1'b1;

    val_in_d  = (state_d == S_ARM) || (state_d == S_LAUNCH) ||
                (state_d == S_CAPTURE) || (state_d == S_WAIT);
    launch_d  = (state_d == S_LAUNCH) || (state_d == S_CAPTURE) || (state_d == S_WAIT);
    capture_d = (state_d == S_CAPTURE) || (state_d == S_WAIT);
    busy_d    = (state_d != S_IDLE);
    valid_d   = (state_d == S_DONE);
    pg_d      = busy_d ? cfg_d.pg : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      err_q      <= 1'b0;
      val_sync_q <= '0;
      launch_q   <= 1'b0;
      capture_q  <= 1'b0;
      val_in_q   <= 1'b0;
      pg_q       <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      min_q      <= min_d;
      max_q      <= max_d;
      err_q      <= err_d;
      val_sync_q <= val_sync_d;
      launch_q   <= launch_d;
      capture_q  <= capture_d;
      val_in_q   <= val_in_d;
      pg_q       <= pg_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign clk_launch  = launch_q;
  assign clk_capture = capture_q;
  assign val_in      = val_in_q;
  assign pg_src      = pg_q[0];
  assign pg_bypass   = pg_q[1];
  assign pg_in       = pg_q[2];
  assign pg_tog      = pg_q[3];
  assign busy        = busy_q;

  assign res_if.res_valid = valid_q;
  assign res_if.res_sum   = sum_q;
  assign res_if.res_mean  = HW_W'(sum_q >> cfg_q.avg_log2);
  assign res_if.res_min   = min_q;
  assign res_if.res_max   = max_q;
  assign res_if.res_err   = err_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: a small TDC model answers each capture,
// a scoreboard holds the expected statistics record for every request.
module tb_tdc_meas_ctrl;
  localparam int N       = 64;
  localparam int HW_W    = 7;
  localparam int MAXL    = 7;
  localparam int TIMEOUT = 255;
  localparam int SUM_W   = HW_W + MAXL;

  logic            clk = 1'b0;
  logic            rst, en, start;
  logic [2:0]      cfg_avg_log2;
  logic [3:0]      cfg_gap, cfg_settle, cfg_pg;
  logic            clk_launch, clk_capture, val_in;
  logic            pg_src, pg_bypass, pg_in, pg_tog;
  logic [HW_W-1:0] hw;
  logic            val_out;
  logic            busy;

  tdc_meas_ctrl_if #(.HW_W(HW_W), .MAX_AVG_LOG2(MAXL)) rif ();

  tdc_meas_ctrl #(.N(N), .HW_W(HW_W), .MAX_AVG_LOG2(MAXL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .cfg_avg_log2(cfg_avg_log2), .cfg_gap(cfg_gap), .cfg_settle(cfg_settle), .cfg_pg(cfg_pg),
    .clk_launch(clk_launch), .clk_capture(clk_capture), .val_in(val_in),
    .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog),
    .hw(hw), .val_out(val_out), .busy(busy), .res_if(rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SUM_W-1:0] sum;
    logic [HW_W-1:0]  mean;
    logic [HW_W-1:0]  mn;
    logic [HW_W-1:0]  mx;
    logic             err;
  } exp_t;

  exp_t            exp_q[$];
  logic [HW_W-1:0] hw_q[$];
  int              tests = 0, fails = 0;
  int              cyc = 0;
  int              tdc_dly = 3;
  bit              tdc_mute = 1'b0;
  int              launch_cnt, launch_cyc, capture_cyc, valid_cyc, run_min, run_max;

  always @(posedge clk) cyc <= cyc + 1;

  // TDC model: result strobe rises tdc_dly cycles into a capture, drops with capture.
  initial begin
    int age;
    age = 0; val_out = 1'b0; hw = '0;
    forever begin
      @(negedge clk);
      if (clk_capture) begin
        age++;
        if (!tdc_mute && age == tdc_dly && hw_q.size() > 0) begin
          hw = hw_q.pop_front();
          val_out = 1'b1;
        end
      end else begin
        age = 0;
        val_out = 1'b0;
      end
    end
  end

  // Edge timestamps and idle-gap lengths, restarted at each busy rise.
  initial begin
    bit pl, pc, pv, pb;
    int zrun;
    pl = 0; pc = 0; pv = 0; pb = 0; zrun = 0;
    launch_cnt = 0; launch_cyc = 0; capture_cyc = 0; valid_cyc = 0; run_min = 1000; run_max = 0;
    forever begin
      @(negedge clk);
      if (busy && !pb) begin launch_cnt = 0; run_min = 1000; run_max = 0; zrun = 0; end
      if (clk_launch && !pl) begin launch_cnt++; launch_cyc = cyc; end
      if (clk_capture && !pc) capture_cyc = cyc;
      if (rif.res_valid && !pv) valid_cyc = cyc;
      if (busy && !val_in) zrun++;
      else if (val_in && zrun > 0) begin
        if (zrun < run_min) run_min = zrun;
        if (zrun > run_max) run_max = zrun;
        zrun = 0;
      end
      pl = clk_launch; pc = clk_capture; pv = rif.res_valid; pb = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic plan(input int n, input int base, input int step, input int avg);
    exp_t e;
    int s, mn, mx;
    s = 0; mn = (1 << HW_W) - 1; mx = 0;
    for (int i = 0; i < n; i++) begin
      int v;
      v = base + i * step;
      hw_q.push_back(HW_W'(v));
      s += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    e.sum = SUM_W'(s); e.mean = HW_W'(s >> avg); e.mn = HW_W'(mn); e.mx = HW_W'(mx); e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic start_meas(input logic [2:0] avg, input logic [3:0] gap,
                            input logic [3:0] settle, input logic [3:0] pg, output int st);
    tick();
    cfg_avg_log2 = avg; cfg_gap = gap; cfg_settle = settle; cfg_pg = pg;
    start = 1'b1;
    st = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (rif.res_valid !== 1'b1 && n < limit) begin tick(); n++; end
    chk({tag, "_valid_seen"}, rif.res_valid, 1);
  endtask

  task automatic check_res(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_sum"},  rif.res_sum,  e.sum);
      chk({tag, "_mean"}, rif.res_mean, e.mean);
      chk({tag, "_min"},  rif.res_min,  e.mn);
      chk({tag, "_max"},  rif.res_max,  e.mx);
      chk({tag, "_err"},  rif.res_err,  e.err);
    end
  endtask

  task automatic handshake(input string tag, input bit with_start);
    rif.res_ready = 1'b1;
    start = with_start;
    tick();
    rif.res_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_idle_busy"},  busy, 0);
    chk({tag, "_idle_valid"}, rif.res_valid, 0);
  endtask

  initial begin
    int st, n, bad;
    exp_t e;
    rst = 1'b1; en = 1'b1; start = 1'b0; rif.res_ready = 1'b0;
    cfg_avg_log2 = '0; cfg_gap = '0; cfg_settle = '0; cfg_pg = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_valid", rif.res_valid, 0);
    chk("rst_drives", {clk_launch, clk_capture, val_in, pg_tog, pg_in, pg_bypass, pg_src}, 0);
    chk("rst_res", {rif.res_sum, rif.res_min, rif.res_max, rif.res_err}, 0);

    // single sample, gap 2, hw 17 three cycles after capture
    tdc_dly = 3;
    plan(1, 17, 0, 0);
    start_meas(3'd0, 4'd2, 4'd3, 4'b1010, st);
    chk("t1_pg", {pg_tog, pg_in, pg_bypass, pg_src}, 4'b1010);
    chk("t1_arm_valin", val_in, 1);
    wait_valid("t1", 100);
    chk("t1_launch_cyc", launch_cyc, st + 2);
    chk("t1_gap", capture_cyc - launch_cyc, 2);
    chk("t1_done_cyc", valid_cyc, st + 2 + 2 + 1 + 3 + 1 + 3);
    check_res("t1");
    handshake("t1", 1'b0);

    // eight samples 10..17
    tdc_dly = 2;
    plan(8, 10, 1, 3);
    start_meas(3'd3, 4'd1, 4'd2, 4'd0, st);
    wait_valid("t2", 400);
    chk("t2_launches", launch_cnt, 8);
    chk("t2_settle_min", run_min, 2);
    chk("t2_settle_max", run_max, 2);
    check_res("t2");
    handshake("t2", 1'b0);

    // timeout: no result strobe
    tdc_mute = 1'b1;
    e.sum = '0; e.mean = '0; e.mn = '1; e.mx = '0; e.err = 1'b1;
    exp_q.push_back(e);
    start_meas(3'd0, 4'd1, 4'd1, 4'd0, st);
    wait_valid("t3", 400);
    chk("t3_timeout_cyc", valid_cyc - (capture_cyc + 1), TIMEOUT + 1);
    check_res("t3");
    handshake("t3", 1'b0);
    tdc_mute = 1'b0;

    // backpressure in DONE, ignored starts
    tdc_dly = 3;
    plan(2, 30, -25, 1);
    start_meas(3'd1, 4'd3, 4'd2, 4'b0101, st);
    wait_valid("t4", 200);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      tick();
      if (rif.res_valid !== 1'b1 || rif.res_sum !== exp_q[0].sum || rif.res_mean !== exp_q[0].mean ||
          rif.res_min !== exp_q[0].mn || rif.res_max !== exp_q[0].mx || rif.res_err !== exp_q[0].err)
        bad++;
    end
    start = 1'b0;
    chk("t4_hold_stable", bad, 0);
    check_res("t4");
    handshake("t4", 1'b1);
    tick();
    chk("t4_start_ignored", busy, 0);
    plan(1, 9, 0, 0);
    start_meas(3'd0, 4'd1, 4'd1, 4'd0, st);
    wait_valid("t4b", 100);
    check_res("t4b");
    handshake("t4b", 1'b0);

    // reset during WAIT of sample 3 of 4
    plan(4, 1, 1, 2);
    start_meas(3'd2, 4'd1, 4'd2, 4'b1111, st);
    n = 0;
    while (!(launch_cnt == 3 && clk_capture) && n < 300) begin tick(); n++; end
    chk("t5_reach_capture3", launch_cnt == 3 && clk_capture, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy", {busy, rif.res_valid}, 0);
    chk("t5_rst_drives", {clk_launch, clk_capture, val_in, pg_tog, pg_in, pg_bypass, pg_src}, 0);
    chk("t5_rst_res", {rif.res_sum, rif.res_mean, rif.res_min, rif.res_max, rif.res_err}, 0);
    exp_q.delete();
    hw_q.delete();
    plan(4, 4, 4, 2);
    start_meas(3'd2, 4'd1, 4'd2, 4'd0, st);
    wait_valid("t5", 300);
    check_res("t5");
    handshake("t5", 1'b0);

    // enable drop during LAUNCH
    plan(1, 5, 0, 0);
    start_meas(3'd0, 4'd4, 4'd1, 4'd0, st);
    n = 0;
    while (clk_launch !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t6_in_launch", clk_launch, 1);
    en = 1'b0;
    tick();
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_drives", {clk_launch, clk_capture, val_in}, 0);
    en = 1'b1;
    repeat (5) tick();
    chk("t6_no_result", rif.res_valid, 0);
    exp_q.delete();
    hw_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
